// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared types and constants for the multiplier-sharing arbiter.
//   OP_W / RES_W : operand and product widths of the 4x4 shift-add core
//   MAX_REQ      : largest supported requester count
//   arb_state_t  : controller state encoding (BYPASS is only reachable when
//                  the design is built with MULT_ARB_BYPASS_ZERO_EN)
//   onehot_to_idx: binary index of a one-hot vector (0 for an all-zero vector)
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int OP_W    = 4;
    localparam int RES_W   = 8;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT    = 3'd3,
        RELEASE = 3'd4,
        DRAIN   = 3'd5,
        BYPASS  = 3'd6
    } arb_state_t;

    // OR-reduction of the set bit positions; exact for one-hot input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at index ptr and wraps
// around; the first requester found wins.
//   NUM_REQ : number of requesters (2..8)
//   PTR_W   : width of the pointer input
//   req     : request vector
//   ptr     : index where the search starts (must be < NUM_REQ)
//   grant   : one-hot winner, all-zero when req is zero
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // cand_idx[gi] is the requester examined at search position gi,
    // i.e. (ptr + gi) mod NUM_REQ. ptr < NUM_REQ so one subtraction suffices.
    logic [PTR_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_req;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [PTR_W:0] sum;
        assign sum          = {1'b0, ptr} + (PTR_W+1)'(gi);
        assign cand_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                              PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && cand_req[i]) begin
                grant[cand_idx[i]] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Shares one 4x4 shift-add multiplier core among NUM_REQ requesters. One owner
// at a time is granted round-robin; the controller drives the core's load and
// start handshake, waits for done, hands the 8-bit product back with a
// one-cycle o_valid, and waits for the core's done to drop before the next
// grant so a stale done cannot end the next multiply early.
//
// Build option: MULT_ARB_BYPASS_ZERO_EN -- when defined, a winner with a zero
// operand is answered directly (o_p=0, o_valid one cycle after the grant
// decision) without touching the core. Undefined: zero operands use the core.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req             per-requester request level
//   i_a, i_b          packed 4-bit operands, requester k at [4k+3:4k]
//   o_grant           one-hot current owner, 0 when idle
//   o_valid           one-cycle result strobe to the owner
//   o_p               product, valid while o_valid is non-zero
//   o_busy            high in every state except IDLE
//   o_mul_load/start  core handshake
//   o_mul_a/b         operands to the core, stable from LOAD to next grant
//   i_mul_done/p      core done flag and product
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req,
    input  logic [OP_W*NUM_REQ-1:0] i_a,
    input  logic [OP_W*NUM_REQ-1:0] i_b,
    output logic [NUM_REQ-1:0]      o_grant,
    output logic [NUM_REQ-1:0]      o_valid,
    output logic [RES_W-1:0]        o_p,
    output logic                    o_busy,
    output logic                    o_mul_load,
    output logic                    o_mul_start,
    output logic [OP_W-1:0]         o_mul_a,
    output logic [OP_W-1:0]         o_mul_b,
    input  logic                    i_mul_done,
    input  logic [RES_W-1:0]        i_mul_p
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_reg, state_next;
    logic [PTR_W-1:0]   ptr_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [OP_W-1:0]    a_reg, b_reg;
    logic [RES_W-1:0]   p_reg;

    logic               any_req;
    logic [NUM_REQ-1:0] win_grant;
    logic [OP_W-1:0]    win_a, win_b;
    logic [IDX_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_after_win;

    // ------------------------------------------------------------------
    // Winner selection and its operands
    // ------------------------------------------------------------------
    assign any_req = |i_req;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (i_req),
        .ptr   (ptr_reg),
        .grant (win_grant)
    );

    // AND-OR mux keyed by the one-hot grant avoids a binary decode step.
    logic [OP_W-1:0] a_sel [NUM_REQ];
    logic [OP_W-1:0] b_sel [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_opsel
        assign a_sel[gi] = win_grant[gi] ? i_a[gi*OP_W +: OP_W] : '0;
        assign b_sel[gi] = win_grant[gi] ? i_b[gi*OP_W +: OP_W] : '0;
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_a = win_a | a_sel[i];
            win_b = win_b | b_sel[i];
        end
    end

    // Pointer moves to winner+1 so the winner becomes lowest priority.
    assign win_idx       = onehot_to_idx(MAX_REQ'(win_grant));
    assign ptr_after_win = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                            : PTR_W'(win_idx + IDX_W'(1));

`ifdef MULT_ARB_BYPASS_ZERO_EN
    logic win_zero;
    assign win_zero = (win_a == '0) || (win_b == '0);
`endif

    // ------------------------------------------------------------------
    // Controller state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        o_mul_load  = 1'b0;
        o_mul_start = 1'b0;
        o_valid     = '0;
        o_busy      = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (any_req) begin
`ifdef MULT_ARB_BYPASS_ZERO_EN
                    state_next = win_zero ? BYPASS : LOAD;
`else
                    state_next = LOAD;
`endif
                end
            end
            LOAD: begin
                o_mul_load = 1'b1;
                state_next = START;
            end
            START: begin
                o_mul_start = 1'b1;
                state_next  = WAIT;
            end
            WAIT: begin
                if (i_mul_done) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // Start pulse here is the core's acknowledge of the result;
                // its done then drops, which DRAIN waits for.
                o_mul_start = 1'b1;
                o_valid     = grant_reg;
                state_next  = DRAIN;
            end
            DRAIN: begin
                if (!i_mul_done) begin
                    state_next = IDLE;
                end
            end
            BYPASS: begin
                o_valid    = grant_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Grant, operand, pointer and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_reg   <= '0;
            grant_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            p_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_req) begin
                        grant_reg <= win_grant;
                        a_reg     <= win_a;
                        b_reg     <= win_b;
                        ptr_reg   <= ptr_after_win;
`ifdef MULT_ARB_BYPASS_ZERO_EN
                        if (win_zero) begin
                            p_reg <= '0;
                        end
`endif
                    end
                end
                WAIT: begin
                    if (i_mul_done) begin
                        p_reg <= i_mul_p;
                    end
                end
                RELEASE, BYPASS: begin
                    grant_reg <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_grant = grant_reg;
    assign o_p     = p_reg;
    assign o_mul_a = a_reg;
    assign o_mul_b = b_reg;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin controller that shares one 4x4 shift-add multiplier core among NUM_REQ requesters. It grants one requester at a time, drives the core's load/start handshake, waits for done, returns the 8-bit product to the winner, and returns the core to idle before the next grant. It sits between the bus-side register slices and the single multiplier instance in the IP core.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  NUM_REQ  per-requester request level, held until own o_valid
- i_a  in  4*NUM_REQ  operand A, requester k at bits [4k+3:4k]
- i_b  in  4*NUM_REQ  operand B, same packing
- o_grant  out  NUM_REQ  one-hot current owner, 0 when idle
- o_valid  out  NUM_REQ  one-cycle result strobe to owner
- o_p  out  8  result bus, valid when any o_valid bit is high
- o_busy  out  1  high in every state except IDLE
- o_mul_load  out  1  to core i_load
- o_mul_start  out  1  to core i_start
- o_mul_a, o_mul_b  out  4  to core i_A / i_B
- i_mul_done  in  1  from core o_done
- i_mul_p  in  8  from core o_P

## Operation
- States: IDLE, LOAD, START, WAIT, RELEASE, DRAIN (plus BYPASS when configured).
- IDLE: if any i_req, the arbiter picks the winner, registers o_grant, latches its operands into o_mul_a/o_mul_b, and advances the pointer to winner+1 (mod NUM_REQ), then goes to LOAD.
- LOAD: o_mul_load=1 for one cycle, then START.
- START: o_mul_start=1 for one cycle, then WAIT.
- WAIT: o_mul_start=0. On i_mul_done=1, register i_mul_p into o_p and go to RELEASE.
- RELEASE: o_mul_start=1 and o_valid[winner]=1 for one cycle. o_grant clears at the end of this cycle. Next state is DRAIN.
- DRAIN: hold until i_mul_done=0, then go to IDLE. This blocks the core's stale done from satisfying the next WAIT.
- Round-robin order: search starts at the pointer and wraps. After reset the pointer is 0.
- The product is exact: 8 bits, unsigned, with no truncation.
- A requester that drops i_req after grant still gets its o_valid. The result is not discarded.
- i_req changes during a non-IDLE state have no effect until the next IDLE.
- o_mul_a and o_mul_b are stable from LOAD until the next grant.

## Timing
- Reset values: o_grant=0, o_valid=0, o_p=0, o_busy=0, o_mul_load=0, o_mul_start=0, o_mul_a=0, o_mul_b=0, pointer=0, state IDLE.
- Assertion of i_rst mid-operation returns the block to IDLE next cycle and drops any pending result. The system resets the core in the same cycle.
- With the core attached, for a request seen in IDLE at cycle 0:
  - LOAD at cycle 1, START at cycle 2.
  - WAIT runs cycles 3-9; i_mul_done is first seen at cycle 9.
  - RELEASE and o_valid at cycle 10.
  - DRAIN at cycles 11-12, IDLE at cycle 13.
- Minimum grant-to-grant spacing is 13 cycles.
- All outputs are registered or decoded from the state register only, with no combinational path from i_req.
- o_valid is asserted only for the granted index, never for more than one bit.

## Configuration
- MULT_ARB_BYPASS_ZERO_EN defined:
  - In IDLE, if the winner's A==0 or B==0, go to BYPASS instead of LOAD. BYPASS asserts o_p=0 and o_valid[winner] for one cycle, then returns to IDLE.
  - The core sees no load/start. The pointer advances as normal.
  - Latency is o_valid at cycle 1.
- MULT_ARB_BYPASS_ZERO_EN undefined: zero operands take the full core path, and the result 0 arrives at cycle 10.

## Structure
- Package mult_arb_pkg holds:
  - OP_W=4 and RES_W=8.
  - The state enum with encodings IDLE=0, LOAD=1, START=2, WAIT=3, RELEASE=4, DRAIN=5, BYPASS=6.
  - MAX_REQ=8.
- Sub-module rr_arbiter(NUM_REQ) takes the request vector and the pointer, and returns a one-hot grant. It is combinational and reused elsewhere. The pointer register stays in mult_arbiter.

## Test plan
- Single request: i_req=0001, A=7, B=9 -> o_grant=0001 at cycle 1, o_valid=0001 with o_p=63 at cycle 10, o_busy low at cycle 13.
- All four requesting continuously with A=k+1, B=15 -> grants in order 0,1,2,3,0, products 15,30,45,60 in that order, 13-cycle spacing.
- Pointer wrap: last grant to req 3, then i_req=1001 -> req 0 is granted.
- Requester 2 drops i_req in WAIT -> o_valid[2] still pulses with the correct product, and the next grant follows normal rotation.
- i_rst in WAIT at cycle 5 -> all outputs at reset values next cycle. A new request after reset completes correctly: 15*15=225.
- A=0, B=12:
  - With MULT_ARB_BYPASS_ZERO_EN, o_valid at cycle 1 with o_p=0 and o_mul_load never asserted.
  - Without it, o_p=0 at cycle 10.
